// File: rtl/mux_2_to_1.sv
// -----------------------------------------------------------------------------
// mux_2_to_1
//
// Two-input, one-select data multiplexer with two result paths:
//   - out       : zero-latency combinational select, sel ? b : a. It never
//                 looks at clk, rst_n or in_valid, so the block still works as
//                 a plain 2:1 mux with the clock and reset tied off.
//   - out_q     : the same selection captured at the rising edge of clk when
//                 in_valid is high; it holds its value otherwise.
//   - out_valid : in_valid delayed by one cycle.
//
// Ports:
//   clk        in   1      rising-edge clock (registered path only)
//   rst_n      in   1      synchronous active-low reset (registered path only)
//   a          in   WIDTH  data chosen when sel = 0
//   b          in   WIDTH  data chosen when sel = 1
//   sel        in   1      select
//   in_valid   in   1      qualifies a/b/sel for capture
//   out        out  WIDTH  combinational result
//   out_q      out  WIDTH  registered result
//   out_valid  out  1      registered copy of in_valid
// -----------------------------------------------------------------------------
module mux_2_to_1 #(
  parameter int WIDTH = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             sel,
  input  logic             in_valid,
  output logic [WIDTH-1:0] out,
  output logic [WIDTH-1:0] out_q,
  output logic             out_valid
);

  logic [WIDTH-1:0] sel_data;
  logic [WIDTH-1:0] data_d;
  logic [WIDTH-1:0] data_q;
  logic             valid_d;
  logic             valid_q;

  // Shared selection feeds both the combinational output and the capture path.
  always_comb begin
    sel_data = sel ? b : a;
  end

  assign out = sel_data;

  // Next state: capture only qualified samples; data holds when idle, while
  // valid is a pure one-cycle delay of in_valid.
  always_comb begin
    data_d  = data_q;
    valid_d = in_valid;
    if (in_valid) begin
      data_d = sel_data;
    end
  end

  // Reset clears both data and valid so out_q is deterministic after reset;
  // it also discards whatever sample is presented on the reset edge.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      data_q  <= '0;
      valid_q <= 1'b0;
    end else begin
      data_q  <= data_d;
      valid_q <= valid_d;
    end
  end

  assign out_q     = data_q;
  assign out_valid = valid_q;

endmodule

// File: tb/tb_mux_2_to_1.sv
// -----------------------------------------------------------------------------
// tb_mux_2_to_1
//
// Directed bench for mux_2_to_1. One WIDTH=1 instance with clk/rst_n tied off
// exercises the pure combinational mux; one WIDTH=8 instance with a running
// clock exercises both the combinational and the registered path.
// -----------------------------------------------------------------------------
module tb_mux_2_to_1;

  int n_chk = 0;
  int n_bad = 0;

  // WIDTH=1 instance, clock and reset tied off
  logic s_a, s_b, s_sel;
  logic s_out, s_out_q, s_out_valid;

  mux_2_to_1 #(.WIDTH(1)) u_w1 (
    .clk       (1'b0),
    .rst_n     (1'b1),
    .a         (s_a),
    .b         (s_b),
    .sel       (s_sel),
    .in_valid  (1'b0),
    .out       (s_out),
    .out_q     (s_out_q),
    .out_valid (s_out_valid)
  );

  // WIDTH=8 instance with a live clock
  logic       clk = 1'b0;
  logic       rst_n;
  logic [7:0] a, b;
  logic       sel;
  logic       in_valid;
  logic [7:0] out, out_q;
  logic       out_valid;

  mux_2_to_1 #(.WIDTH(8)) u_w8 (
    .clk       (clk),
    .rst_n     (rst_n),
    .a         (a),
    .b         (b),
    .sel       (sel),
    .in_valid  (in_valid),
    .out       (out),
    .out_q     (out_q),
    .out_valid (out_valid)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%h expected=%h", tag, got, exp);
    end
  endtask

  // Sample just after the active edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Drive stimulus away from the active edge.
  task automatic drive(input logic r, input logic v, input logic s,
                       input logic [7:0] da, input logic [7:0] db);
    @(negedge clk);
    rst_n    = r;
    in_valid = v;
    sel      = s;
    a        = da;
    b        = db;
  endtask

  initial begin
    rst_n = 1'b0; in_valid = 1'b0; sel = 1'b0; a = 8'h00; b = 8'h00;

    // Combinational path on the tied-off instance
    s_sel = 1'b0; s_a = 1'b1; s_b = 1'b0;
    #10;
    check("w1_sel0", {7'd0, s_out}, 8'h01);
    s_sel = 1'b1;
    #10;
    check("w1_sel1", {7'd0, s_out}, 8'h00);

    // Exhaustive WIDTH=1 truth table: index bits {sel, b, a}
    for (int i = 0; i < 8; i++) begin
      logic [2:0] v;
      logic       e;
      v = i[2:0];
      s_a = v[0]; s_b = v[1]; s_sel = v[2];
      // Expected values written out from the truth table.
      case (v)
        3'b000: e = 1'b0;
        3'b001: e = 1'b1;
        3'b010: e = 1'b0;
        3'b011: e = 1'b1;
        3'b100: e = 1'b0;
        3'b101: e = 1'b0;
        3'b110: e = 1'b1;
        default: e = 1'b1;
      endcase
      #10;
      check($sformatf("w1_tt%0d", i), {7'd0, s_out}, {7'd0, e});
    end

    // WIDTH=8 combinational select
    a = 8'hA5; b = 8'h3C; sel = 1'b0;
    #1;
    check("w8_comb_a", out, 8'hA5);
    sel = 1'b1;
    #1;
    check("w8_comb_b", out, 8'h3C);

    // Reset held for two edges
    drive(1'b0, 1'b0, 1'b0, 8'hA5, 8'h3C);
    tick();
    tick();
    check("rst_out_q", out_q, 8'h00);
    check("rst_out_valid", {7'd0, out_valid}, 8'h00);

    // First capture after release
    drive(1'b1, 1'b1, 1'b1, 8'h00, 8'h3C);
    tick();
    check("cap_out_q", out_q, 8'h3C);
    check("cap_out_valid", {7'd0, out_valid}, 8'h01);

    // Hold while idle; out keeps tracking the inputs
    drive(1'b1, 1'b0, 1'b0, 8'h11, 8'h22);
    #1;
    check("hold_comb_a", out, 8'h11);
    sel = 1'b1;
    #1;
    check("hold_comb_b", out, 8'h22);
    tick();
    check("hold_out_q", out_q, 8'h3C);
    check("hold_out_valid", {7'd0, out_valid}, 8'h00);
    a = 8'h99; b = 8'h77; sel = 1'b0;
    tick();
    check("hold2_out_q", out_q, 8'h3C);

    // Only the edge-sampled value is captured
    drive(1'b1, 1'b1, 1'b1, 8'h00, 8'h55);
    tick();
    b = 8'h66;
    #2;
    check("between_out_q", out_q, 8'h55);

    // Back-to-back valid stream from a
    drive(1'b1, 1'b1, 1'b0, 8'h01, 8'hEE);
    tick();
    check("stream0_out_q", out_q, 8'h01);
    drive(1'b1, 1'b1, 1'b0, 8'h80, 8'hEE);
    tick();
    check("stream1_out_q", out_q, 8'h80);
    drive(1'b1, 1'b1, 1'b0, 8'hFF, 8'h00);
    tick();
    check("stream2_out_q", out_q, 8'hFF);
    check("stream2_out_valid", {7'd0, out_valid}, 8'h01);

    // Mid-stream reset discards the sample on that edge
    drive(1'b0, 1'b1, 1'b0, 8'h77, 8'h12);
    tick();
    check("midrst_out_q", out_q, 8'h00);
    check("midrst_out_valid", {7'd0, out_valid}, 8'h00);
    check("midrst_comb", out, 8'h77);
    sel = 1'b1;
    #1;
    check("midrst_comb_b", out, 8'h12);

    // Recovery after reset
    drive(1'b1, 1'b1, 1'b0, 8'h42, 8'h24);
    tick();
    check("recover_out_q", out_q, 8'h42);
    check("recover_out_valid", {7'd0, out_valid}, 8'h01);

    // Equal inputs: sel is irrelevant
    drive(1'b1, 1'b1, 1'b0, 8'h5A, 8'h5A);
    #1;
    check("eq_comb_sel0", out, 8'h5A);
    sel = 1'b1;
    #1;
    check("eq_comb_sel1", out, 8'h5A);
    tick();
    check("eq_out_q", out_q, 8'h5A);

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

endmodule
